// File: rtl/ram_dma_copier.sv
// ram_dma_copier
// Word-granular DMA copy engine sharing the data-RAM port with the CPU.
// It copies len_words 32-bit words from src_addr to dst_addr by alternating
// RAM reads and writes. It only advances while the arbiter asserts bus_gnt.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start               one-cycle request, only honoured in IDLE
//   src_addr, dst_addr  byte addresses, low two bits dropped on capture
//   len_words           number of words to copy (0 = no RAM access)
//   fill_mode,
//   fill_value          only with DMA_FILL_EN: write fill_value instead of copying
//   bus_gnt             arbiter grant for the data-RAM port
//   busy, done          status; done is a one-cycle completion pulse
//   ram_*               RAM initiator port; read data is valid in the same cycle
//
// Optional feature macro: DMA_FILL_EN (fill mode). The default build is copy-only.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | zero-length test on the captured count
// READ   | fetch one source word into the buffer (needs grant)
// WRITE  | store the buffer to the destination (needs grant)
// DONE   | one-cycle done pulse
module ram_dma_copier #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    len_words,
`ifdef DMA_FILL_EN
  input  logic                fill_mode,
  input  logic [DATA_W-1:0]   fill_value,
`endif
  input  logic                bus_gnt,
  output logic                busy,
  output logic                done,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t             state;
  logic [ADDR_W-1:0]  src;
  logic [ADDR_W-1:0]  dst;
  logic [LEN_W-1:0]   count;
  logic [DATA_W-1:0]  buffer;

`ifdef DMA_FILL_EN
  logic fill_q;
`else
  localparam logic fill_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      src    <= '0;
      dst    <= '0;
      count  <= '0;
      buffer <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src   <= src_addr & ALIGN_MASK;
            dst   <= dst_addr & ALIGN_MASK;
            count <= len_words;
`ifdef DMA_FILL_EN
            // Fill mode preloads the buffer once; WRITE then repeats it.
            fill_q <= fill_mode;
            if (fill_mode) buffer <= fill_value;
`endif
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (count == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= fill_q ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (bus_gnt) begin
            buffer <= ram_data_i;
            src    <= src + WORD_STEP;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus_gnt) begin
            dst   <= dst + WORD_STEP;
            count <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= fill_q ? S_WRITE : S_READ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM port is combinational so a granted access happens in the grant cycle;
  // every field stays zero unless ce is asserted.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_sel_o  = '0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (bus_gnt && state == S_READ) begin
      ram_ce_o   = 1'b1;
      ram_sel_o  = '1;
      ram_addr_o = src;
    end else if (bus_gnt && state == S_WRITE) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = 1'b1;
      ram_sel_o  = '1;
      ram_addr_o = dst;
      ram_data_o = buffer;
    end
  end

endmodule

// File: tb/tb_ram_dma_copier.sv
// Testbench for ram_dma_copier: directed scenarios with a scoreboard queue of
// expected RAM accesses and done pulses, popped by a negedge monitor.
module tb_ram_dma_copier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        fill_mode;
  logic [31:0] fill_value;
  logic        bus_gnt;
  logic        busy, done;
  logic        ram_ce_o, ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  ram_dma_copier #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
`ifdef DMA_FILL_EN
    .fill_mode(fill_mode), .fill_value(fill_value),
`endif
    .bus_gnt(bus_gnt), .busy(busy), .done(done),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // RAM model: combinational read, write on the rising edge.
  assign ram_data_i = mem[ram_addr_o[11:2]];
  always @(posedge clk) if (ram_ce_o && ram_we_o) mem[ram_addr_o[11:2]] <= ram_data_o;

  // kind: 0 = read, 1 = write, 2 = done pulse
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t x;
    x.kind = kind; x.addr = addr; x.data = data;
    q.push_back(x);
  endtask

  // Monitor: every RAM access and done pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !bus_gnt) chk("ce_low_without_grant", 64'(ram_ce_o), 64'd0);
      if (ram_ce_o) begin
        if (q.size() == 0) chk("unexpected_access", 64'(ram_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = q.pop_front();
          chk("access_kind", 64'({1'b0, ram_we_o}), 64'(e.kind));
          chk("access_addr", 64'(ram_addr_o), 64'(e.addr));
          chk("access_sel", 64'(ram_sel_o), 64'hF);
          if (e.kind == 2'd1) chk("write_data", 64'(ram_data_o), 64'(e.data));
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("done_kind", 64'(e.kind), 64'd2);
        end
      end
    end
  end

  // Issue one start and wait for done; toggle selects the 1,0,0,1 grant pattern.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input bit toggle, input int exp_lat);
    int cyc, busy_cnt;
    bit timed_out;
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bus_gnt = 1'b1;
    cyc = 0; busy_cnt = 0; timed_out = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (busy) busy_cnt++;
      if (cyc > 200) begin timed_out = 1; break; end
      @(posedge clk);
      #1 bus_gnt = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end
    if (timed_out) chk("done_timeout", 64'(cyc), 64'(exp_lat));
    else begin
      chk("done_latency", 64'(cyc), 64'(exp_lat));
      chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
    end
    bus_gnt = 1'b1;
  endtask

  localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002,
                          WC = 32'hC000_0003, WD = 32'hD000_0004;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1111_0000 + 32'(i);
    mem[64] = WA; mem[65] = WB; mem[66] = WC; mem[67] = WD;
    mem[10'h3FE] = 32'h0BAD_F00D; mem[10'h3FF] = 32'h1234_5678; mem[0] = 32'h8765_4321;
    for (int i = 0; i < 4; i++) mem[192 + i] = 32'h5A5A_0000 + 32'(i);

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
    fill_mode = 1'b0; fill_value = '0; bus_gnt = 1'b1;
    #1;
    chk("reset_ctrl", 64'({busy, done, ram_ce_o, ram_we_o, ram_sel_o}), 64'd0);
    chk("reset_addr", 64'(ram_addr_o), 64'd0);
    chk("reset_data", 64'(ram_data_o), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Plain 4-word copy at full grant.
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 32'h100 + 32'(4*i), 32'h0);
      push(2'd1, 32'h200 + 32'(4*i), (i == 0) ? WA : (i == 1) ? WB : (i == 2) ? WC : WD);
    end
    push(2'd2, 32'h0, 32'h0);
    run(32'h100, 32'h200, 16'd4, 1'b0, 10);
    chk("copy_w0", 64'(mem[128]), 64'(WA));
    chk("copy_w1", 64'(mem[129]), 64'(WB));
    chk("copy_w2", 64'(mem[130]), 64'(WC));
    chk("copy_w3", 64'(mem[131]), 64'(WD));

    // Zero length: only the done pulse is expected.
    push(2'd2, 32'h0, 32'h0);
    run(32'h100, 32'h200, 16'd0, 1'b0, 2);

    // Grant pattern 1,0,0,1 adds 8 stalled cycles over 4 words.
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 32'h100 + 32'(4*i), 32'h0);
      push(2'd1, 32'h280 + 32'(4*i), (i == 0) ? WA : (i == 1) ? WB : (i == 2) ? WC : WD);
    end
    push(2'd2, 32'h0, 32'h0);
    run(32'h100, 32'h283, 16'd4, 1'b1, 18);
    chk("stall_w0", 64'(mem[160]), 64'(WA));
    chk("stall_w3", 64'(mem[163]), 64'(WD));

    // Source wraps through the top of the address space.
    push(2'd0, 32'hFFFF_FFF8, 32'h0); push(2'd1, 32'h10, 32'h0BAD_F00D);
    push(2'd0, 32'hFFFF_FFFC, 32'h0); push(2'd1, 32'h14, 32'h1234_5678);
    push(2'd0, 32'h0000_0000, 32'h0); push(2'd1, 32'h18, 32'h8765_4321);
    push(2'd2, 32'h0, 32'h0);
    run(32'hFFFF_FFF9, 32'h10, 16'd3, 1'b0, 8);
    chk("wrap_w0", 64'(mem[4]), 64'h0BAD_F00D);
    chk("wrap_w2", 64'(mem[6]), 64'h8765_4321);

    // Reset during the write of word 2 of 4.
    push(2'd0, 32'h100, 32'h0); push(2'd1, 32'h300, WA);
    push(2'd0, 32'h104, 32'h0); push(2'd1, 32'h304, WB);
    @(negedge clk);
    src_addr = 32'h100; dst_addr = 32'h300; len_words = 16'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", 64'({busy, done, ram_ce_o, ram_we_o, ram_sel_o}), 64'd0);
    chk("rst_mid_addr", 64'(ram_addr_o), 64'd0);
    chk("rst_mid_data", 64'(ram_data_o), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_queue_drained", 64'(q.size()), 64'd0);
    chk("rst_w0_written", 64'(mem[192]), 64'(WA));
    chk("rst_w2_untouched", 64'(mem[194]), 64'h5A5A_0002);
    chk("rst_w3_untouched", 64'(mem[195]), 64'h5A5A_0003);
    push(2'd0, 32'h108, 32'h0); push(2'd1, 32'h300, WC); push(2'd2, 32'h0, 32'h0);
    run(32'h108, 32'h300, 16'd1, 1'b0, 4);
    chk("after_rst_copy", 64'(mem[192]), 64'(WC));

`ifdef DMA_FILL_EN
    // Fill mode: writes only, one cycle per word.
    fill_mode = 1'b1; fill_value = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) push(2'd1, 32'h40 + 32'(4*i), 32'hDEAD_BEEF);
    push(2'd2, 32'h0, 32'h0);
    run(32'h100, 32'h40, 16'd3, 1'b0, 5);
    fill_mode = 1'b0;
    chk("fill_w0", 64'(mem[16]), 64'hDEAD_BEEF);
    chk("fill_w2", 64'(mem[18]), 64'hDEAD_BEEF);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
